hazard_forward_ctrl: RTL

Pipeline hazard and forwarding controller for the 5-stage datapath. Shadows the destination-register information of the instructions in EX, MEM and WB, and produces registered 2-bit forwarding selects for the two EX-stage operand muxes (00 = register file, 10 = EX/MEM result, 01 = MEM/WB result). It also produces the load-use stall and bubble controls for PC, IF/ID and ID/EX. It sits between ID decode and the EX operand muxes.

---
 rtl/hazard_forward_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX-operand forwarding selects plus load-use stall/bubble
// control for the 5-stage pipeline. Shadows dest/reg_write/mem_read/valid of
// the instructions in EX, MEM and WB.
// Macro HAZARD_FORWARDING_EN: defined -> forwarding with single-bubble
// load-use stall; undefined -> no forwarding, stall until EX/MEM no longer
// write a used source.
module hazard_forward_ctrl #(
  parameter int REG_BITS = 5,
  parameter int SEL_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                flush,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic [REG_BITS-1:0] id_dest,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  output logic [SEL_BITS-1:0] forward_a,
  output logic [SEL_BITS-1:0] forward_b,
  output logic                stall,
  output logic                bubble
);

  typedef enum logic {RUN, LDSTALL} state_t;

  state_t state, state_nx;

  logic                ex_vld, ex_rw, ex_mr;
  logic [REG_BITS-1:0] ex_dest;
  logic                mem_vld, mem_rw, mem_mr;
  logic [REG_BITS-1:0] mem_dest;
  logic                wb_vld, wb_rw, wb_mr;
  logic [REG_BITS-1:0] wb_dest;
  logic                hazard;

  // A stage "writes r": valid, writes the RF, same index, and r is not r0.
  function automatic logic writes(input logic v, input logic rw,
                                  input logic [REG_BITS-1:0] d,
                                  input logic [REG_BITS-1:0] r);
    return v & rw & (d == r) & (r != '0);
  endfunction

`ifdef HAZARD_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time; ALU results are bypassed.
  // The LDSTALL gate is redundant with the EX bubble but makes the 1-cycle
  // cost explicit.
  assign hazard = (state == RUN) & ex_vld & ex_mr &
                  ((id_use_rs & writes(ex_vld, ex_rw, ex_dest, id_rs)) |
                   (id_use_rt & writes(ex_vld, ex_rw, ex_dest, id_rt)));
`else
  // No bypass: wait until neither EX nor MEM writes a used source. WB is
  // not checked because the RF writes in the first half-cycle.
  assign hazard =
    (id_use_rs & (writes(ex_vld, ex_rw, ex_dest, id_rs) |
                  writes(mem_vld, mem_rw, mem_dest, id_rs))) |
    (id_use_rt & (writes(ex_vld, ex_rw, ex_dest, id_rt) |
                  writes(mem_vld, mem_rw, mem_dest, id_rt)));
`endif

  // A flushed ID instruction is discarded, so there is nothing to hold back.
  assign stall  = hazard & ~flush;
  assign bubble = hazard | flush;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  // FSM next state: LDSTALL marks the cycle the stalled consumer waits
  always_comb begin
    state_nx = state;
    if (!hold) begin
      case (state)
        RUN:     if (stall) state_nx = LDSTALL;
`ifdef HAZARD_FORWARDING_EN
        LDSTALL: state_nx = RUN;
`else
        LDSTALL: if (!stall) state_nx = RUN;
`endif
        default: state_nx = RUN;
      endcase
    end
  end

  // Shadow pipeline; a bubble enters EX as an invalid, non-writing slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_vld  <= 1'b0; ex_rw  <= 1'b0; ex_mr  <= 1'b0; ex_dest  <= '0;
      mem_vld <= 1'b0; mem_rw <= 1'b0; mem_mr <= 1'b0; mem_dest <= '0;
      wb_vld  <= 1'b0; wb_rw  <= 1'b0; wb_mr  <= 1'b0; wb_dest  <= '0;
    end else if (!hold) begin
      wb_vld  <= mem_vld; wb_rw  <= mem_rw; wb_mr  <= mem_mr; wb_dest  <= mem_dest;
      mem_vld <= ex_vld;  mem_rw <= ex_rw;  mem_mr <= ex_mr;  mem_dest <= ex_dest;
      ex_vld  <= ~bubble;
      ex_rw   <= id_reg_write & ~bubble;
      ex_mr   <= id_mem_read & ~bubble;
      ex_dest <= id_dest;
    end
  end

  // WB (and MEM load flag) is tracked for visibility but never consulted.
  logic unused_shadow;
  assign unused_shadow = ^{wb_vld, wb_rw, wb_mr, wb_dest, mem_mr, ex_mr};

`ifdef HAZARD_FORWARDING_EN
  localparam logic [SEL_BITS-1:0] FWD_RF    = SEL_BITS'(0);
  localparam logic [SEL_BITS-1:0] FWD_MEMWB = SEL_BITS'(1);
  localparam logic [SEL_BITS-1:0] FWD_EXMEM = SEL_BITS'(2);

  // Select for the instruction entering EX: current EX is next cycle's
  // EX/MEM (priority), current MEM is next cycle's MEM/WB.
  function automatic logic [SEL_BITS-1:0] fsel(input logic [REG_BITS-1:0] r,
                                               input logic u);
    if (!u)                                     return FWD_RF;
    if (writes(ex_vld, ex_rw, ex_dest, r))      return FWD_EXMEM;
    if (writes(mem_vld, mem_rw, mem_dest, r))   return FWD_MEMWB;
    return FWD_RF;
  endfunction

  // Registered selects, stable for the whole EX cycle of the instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      forward_a <= FWD_RF;
      forward_b <= FWD_RF;
    end else if (!hold) begin
      forward_a <= bubble ? FWD_RF : fsel(id_rs, id_use_rs);
      forward_b <= bubble ? FWD_RF : fsel(id_rt, id_use_rt);
    end
  end
`else
  assign forward_a = '0;
  assign forward_b = '0;
`endif

endmodule
